addsub_share_sched: RTL

- Round-robin scheduler that shares one WIDTH-bit adder with carry-in among NREQ requesters.
- Subtraction uses the same adder as z + ~x + 1.
- The two-op request (z+x)-z is sequenced as two adder passes through an internal result register.
- It sits between requesting pipeline stages and the single shared add/sub unit, and returns one tagged result at a time.

---
 rtl/addsub_share_sched.sv | 191 +++++++++++++++++++
 1 files changed

// File: rtl/addsub_share_sched.sv
// Round-robin scheduler sharing one WIDTH-bit adder (with carry-in) among NREQ
// requesters; returns one tagged result at a time.
//
// state | meaning
// IDLE  | no work in flight; combinational grant to next requester from rr_ptr
// EXEC1 | first adder pass (ADD/SUB/RSUB result, or z+x for TWO)
// EXEC2 | second pass for TWO: held result minus z
// RESP  | result presented until rsp_ready handshake
module addsub_share_sched #(
   parameter int WIDTH = 8,
   parameter int NREQ  = 2,
   parameter int IDW   = 3
) (
   input  logic                    CLK,
   input  logic                    ASYNCRESETN,
   input  logic [NREQ-1:0]         req_valid,
   output logic [NREQ-1:0]         req_ready,
   input  logic [2*NREQ-1:0]       req_op,
   input  logic [WIDTH*NREQ-1:0]   req_z,
   input  logic [WIDTH*NREQ-1:0]   req_x,
   output logic                    rsp_valid,
   input  logic                    rsp_ready,
   output logic [WIDTH-1:0]        rsp_a,
   output logic [IDW-1:0]          rsp_id,
   output logic                    busy
);

   localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

   localparam logic [1:0] OP_ADD  = 2'd0;
   localparam logic [1:0] OP_SUB  = 2'd1;
   localparam logic [1:0] OP_TWO  = 2'd2;
   localparam logic [1:0] OP_RSUB = 2'd3;

   typedef enum logic [1:0] {IDLE, EXEC1, EXEC2, RESP} state_t;

   state_t            state_q, state_d;
   logic [PW-1:0]     rr_ptr_q, rr_ptr_d;
   logic [1:0]        op_q, op_d;
   logic [WIDTH-1:0]  z_q, z_d;
   logic [WIDTH-1:0]  x_q, x_d;
   logic [WIDTH-1:0]  r_q, r_d;
   logic [WIDTH-1:0]  rsp_a_q, rsp_a_d;
   logic [IDW-1:0]    rsp_id_q, rsp_id_d;
   logic              rsp_valid_q, rsp_valid_d;

   logic [WIDTH-1:0]  z_arr  [NREQ];
   logic [WIDTH-1:0]  x_arr  [NREQ];
   logic [1:0]        op_arr [NREQ];

   logic              gnt_any;
   logic [PW-1:0]     gnt_idx;
   logic [PW:0]       scan;

   logic [WIDTH-1:0]  add_a, add_b, add_sum;
   logic              add_cin;

   always_comb begin
      for (int j = 0; j < NREQ; j++) begin
         z_arr[j]  = req_z[j*WIDTH +: WIDTH];
         x_arr[j]  = req_x[j*WIDTH +: WIDTH];
         op_arr[j] = req_op[j*2 +: 2];
      end
   end

   // first valid requester at or above rr_ptr, wrapping modulo NREQ
   always_comb begin
      gnt_any = 1'b0;
      gnt_idx = '0;
      scan    = '0;
      for (int i = 0; i < NREQ; i++) begin
         scan = {1'b0, rr_ptr_q} + (PW+1)'(i);
         if (scan >= (PW+1)'(NREQ)) scan = scan - (PW+1)'(NREQ);
         if (!gnt_any && req_valid[scan[PW-1:0]]) begin
            gnt_any = 1'b1;
            gnt_idx = scan[PW-1:0];
         end
      end
   end

   always_comb begin
      req_ready = '0;
      if (state_q == IDLE && ASYNCRESETN && gnt_any) req_ready[gnt_idx] = 1'b1;
   end

   // the single shared adder; subtraction is A + ~B + 1
   always_comb begin
      add_a   = z_q;
      add_b   = x_q;
      add_cin = 1'b0;
      case (state_q)
         EXEC1: begin
            case (op_q)
               OP_SUB: begin
                  add_b   = ~x_q;
                  add_cin = 1'b1;
               end
               OP_RSUB: begin
                  add_a   = x_q;
                  add_b   = ~z_q;
                  add_cin = 1'b1;
               end
               default: ;
            endcase
         end
         EXEC2: begin
            add_a   = r_q;
            add_b   = ~z_q;
            add_cin = 1'b1;
         end
         default: ;
      endcase
      add_sum = add_a + add_b + WIDTH'(add_cin);
   end

   always_comb begin
      state_d     = state_q;
      rr_ptr_d    = rr_ptr_q;
      op_d        = op_q;
      z_d         = z_q;
      x_d         = x_q;
      r_d         = r_q;
      rsp_a_d     = rsp_a_q;
      rsp_id_d    = rsp_id_q;
      rsp_valid_d = rsp_valid_q;
      case (state_q)
         IDLE: begin
            if (gnt_any) begin
               op_d     = op_arr[gnt_idx];
               z_d      = z_arr[gnt_idx];
               x_d      = x_arr[gnt_idx];
               rsp_id_d = IDW'(gnt_idx);
               rr_ptr_d = (gnt_idx == PW'(NREQ-1)) ? '0 : gnt_idx + 1'b1;
               state_d  = EXEC1;
            end
         end
         EXEC1: begin
            if (op_q == OP_TWO) begin
               r_d     = add_sum;
               state_d = EXEC2;
            end else begin
               rsp_a_d     = add_sum;
               rsp_valid_d = 1'b1;
               state_d     = RESP;
            end
         end
         EXEC2: begin
            rsp_a_d     = add_sum;
            rsp_valid_d = 1'b1;
            state_d     = RESP;
         end
         RESP: begin
            if (rsp_ready) begin
               rsp_valid_d = 1'b0;
               state_d     = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge CLK or negedge ASYNCRESETN) begin
      if (!ASYNCRESETN) begin
         state_q     <= IDLE;
         rr_ptr_q    <= '0;
         op_q        <= OP_ADD;
         z_q         <= '0;
         x_q         <= '0;
         r_q         <= '0;
         rsp_a_q     <= '0;
         rsp_id_q    <= '0;
         rsp_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         rr_ptr_q    <= rr_ptr_d;
         op_q        <= op_d;
         z_q         <= z_d;
         x_q         <= x_d;
         r_q         <= r_d;
         rsp_a_q     <= rsp_a_d;
         rsp_id_q    <= rsp_id_d;
         rsp_valid_q <= rsp_valid_d;
      end
   end

   assign rsp_valid = rsp_valid_q;
   assign rsp_a     = rsp_a_q;
   assign rsp_id    = rsp_id_q;
   assign busy      = (state_q != IDLE);

endmodule
